grayscale_conv_unclk: RTL and testbench
=======================================

// Module: grayscale_conv_unclk
// PURPOSE
//  Luma (grayscale) converter for the colour-highlight video path.
//  - Maps one 8-bit RGB pixel to one 8-bit gray value on an unclocked (combinational) output.
//  - colordetc uses that value to replace non-highlighted pixels.
//  - Also provides a 1-cycle registered copy and a running peak-luma monitor for debug/AE use.
// PARAMETERS
//  W_R  default 77   red weight, unsigned, 0..255
//  W_G  default 150  green weight, unsigned, 0..255
//  W_B  default 29   blue weight, unsigned, 0..255
//  Defaults sum to 256, i.e. BT.601 scaled by 256.
// PORTS
//  clk      in   1  pixel clock; the only clock
//  rst      in   1  reset, synchronous, active-high
//  in_r     in   8  red component, unsigned
//  in_g     in   8  green component, unsigned
//  in_b     in   8  blue component, unsigned
//  gs       out  8  combinational gray value of the current inputs
//  gs_q     out  8  gs registered on clk (1-cycle latency)
//  gs_peak  out  8  largest gs sampled since the last reset
//  Port order after clk/rst: in_r, in_g, in_b, gs, gs_q, gs_peak.
//  This order lets colordetc connect positionally: (in_r,in_g,in_b,gs,,).
// BEHAVIOUR
//  - Arithmetic:
//    - sum = W_R*in_r + W_G*in_g + W_B*in_b + RND.
//    - sum is unsigned, at least 18 bits wide, so it never overflows for any weights.
//    - RND = 128 if GRAY_ROUND_EN is defined, else 0.
//    - gs = sum>>8 when sum>>8 <= 255, else 255 (saturate; only possible with non-default weights).
//  - gs path:
//    - purely combinational, no clock or reset dependency.
//    - changes in the same delta as its inputs; zero latency.
//  - gs_q:
//    - on every rising clk, gs_q <= gs.
//    - if rst=1 at the edge, gs_q <= 0.
//  - gs_peak:
//    - on every rising clk, gs_peak <= max(gs_peak, gs).
//    - if rst=1 at the edge, gs_peak <= 0.
//    - when gs equals gs_peak, the value is held (no change).
//    - saturates naturally at 255.
//  - Reset values: gs_q=0, gs_peak=0. gs follows its inputs even while rst=1.
//  - Reset asserted mid-stream:
//    - the registered outputs clear on that edge.
//    - the first edge with rst=0 samples the current gs.
//  - No handshake: a new pixel is accepted every cycle; inputs are assumed valid every cycle.
//  - No latches; all registers update only on posedge clk.
// CONFIGURATION
//  GRAY_ROUND_EN
//    - defined: round-to-nearest (+128 before >>8).
//    - undefined (default): truncate (floor).
//    - Affects gs and therefore gs_q and gs_peak.
// TESTING
//  1) in=(0,0,0) -> gs=0. in=(255,255,255) -> gs=255 (both rounding modes).
//  2) Primaries, truncating:
//     - (255,0,0) -> 76
//     - (0,255,0) -> 149
//     - (0,0,255) -> 28
//     Same inputs with GRAY_ROUND_EN: 77, 149, 29.
//  3) Drive the sequence 10,200,50 gray (R=G=B) over three cycles, then hold:
//     - gs_q lags gs by exactly 1 cycle: 0,10,200,50.
//     - gs_peak = 0,10,200,200.
//  4) Assert rst for 1 cycle with gs_peak=200 and inputs held at (50,50,50):
//     - gs=50 throughout rst.
//     - after the rst edge: gs_q=0, gs_peak=0.
//     - on the next edge: gs_q=50, gs_peak=50.
//  5) Override W_R=W_G=W_B=255 with in=(255,255,255) -> gs saturates to 255 (no wrap).
//  6) Random sweep of 10k pixels:
//     - compare gs against a reference model of the sum formula.
//     - compare gs_peak against a running max.

Source files
------------

// File: rtl/grayscale_conv_unclk_if.sv
// Pixel bundle for the luma converter: RGB in, gray/registered/peak out.
// Shared by the converter's users and the bench.
interface grayscale_conv_unclk_if;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic [7:0] gs;
  logic [7:0] gs_q;
  logic [7:0] gs_peak;

  modport master (
    output in_r, in_g, in_b,
    input  gs, gs_q, gs_peak
  );

  modport slave (
    input  in_r, in_g, in_b,
    output gs, gs_q, gs_peak
  );
endinterface

// File: rtl/grayscale_conv_unclk.sv
// Luma converter: combinational gray value plus registered copy and peak.
// Define GRAY_ROUND_EN for round-to-nearest; default build truncates.
module grayscale_conv_unclk #(
  parameter int unsigned W_R = 77,
  parameter int unsigned W_G = 150,
  parameter int unsigned W_B = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic [7:0] gs,
  output logic [7:0] gs_q,
  output logic [7:0] gs_peak
);

  localparam logic [7:0] WR = 8'(W_R);
  localparam logic [7:0] WG = 8'(W_G);
  localparam logic [7:0] WB = 8'(W_B);

`ifdef GRAY_ROUND_EN
  localparam logic [17:0] RND = 18'd128;
`else
  localparam logic [17:0] RND = 18'd0;
`endif

  logic [17:0] sum;
  logic [9:0]  hi;
  logic        unused_lo;

  // 3*255*255+128 < 2^18, so the sum cannot overflow for any weights
  always_comb begin
    sum = 18'(WR) * 18'(in_r)
        + 18'(WG) * 18'(in_g)
        + 18'(WB) * 18'(in_b)
        + RND;
    hi  = sum[17:8];
    gs  = (hi > 10'd255) ? 8'hFF : hi[7:0];
  end

  assign unused_lo = &{1'b0, sum[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      gs_q    <= 8'd0;
      gs_peak <= 8'd0;
    end else begin
      gs_q <= gs;
      if (gs > gs_peak)
        gs_peak <= gs;
    end
  end

endmodule

// File: tb/tb_grayscale_conv_unclk.sv
// Self-checking bench: directed corner cases plus a random sweep
// against an arithmetic luma model with running max.
module tb_grayscale_conv_unclk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grayscale_conv_unclk_if pix();

  grayscale_conv_unclk dut (
    .clk     (clk),
    .rst     (rst),
    .in_r    (pix.in_r),
    .in_g    (pix.in_g),
    .in_b    (pix.in_b),
    .gs      (pix.gs),
    .gs_q    (pix.gs_q),
    .gs_peak (pix.gs_peak)
  );

  logic [7:0] s_r, s_g, s_b;
  logic [7:0] s_gs, s_q, s_pk;

  grayscale_conv_unclk #(
    .W_R (255),
    .W_G (255),
    .W_B (255)
  ) sat (
    .clk     (clk),
    .rst     (rst),
    .in_r    (s_r),
    .in_g    (s_g),
    .in_b    (s_b),
    .gs      (s_gs),
    .gs_q    (s_q),
    .gs_peak (s_pk)
  );

  int checks = 0;
  int failures = 0;
  int m_q = 0;
  int m_pk = 0;

`ifdef GRAY_ROUND_EN
  localparam int RND = 128;
  localparam int EXP_R = 77;
  localparam int EXP_B = 29;
`else
  localparam int RND = 0;
  localparam int EXP_R = 76;
  localparam int EXP_B = 28;
`endif

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gs(input int r, input int g, input int b);
    int v;
    v = (77 * r + 150 * g + 29 * b + RND) / 256;
    return (v > 255) ? 255 : v;
  endfunction

  // Drive one pixel, check gs, clock it in, check registered outputs
  task automatic drive(input int r, input int g, input int b,
                       input bit rst_v);
    int e;
    pix.in_r = 8'(r);
    pix.in_g = 8'(g);
    pix.in_b = 8'(b);
    rst = rst_v;
    #1;
    e = ref_gs(r, g, b);
    check("gs", int'(pix.gs), e);
    @(posedge clk);
    if (rst_v) begin
      m_q = 0;
      m_pk = 0;
    end else begin
      m_q = e;
      if (e > m_pk) m_pk = e;
    end
    #1;
    check("gs_q", int'(pix.gs_q), m_q);
    check("gs_peak", int'(pix.gs_peak), m_pk);
  endtask

  initial begin
    pix.in_r = 8'd0;
    pix.in_g = 8'd0;
    pix.in_b = 8'd0;
    s_r = 8'd255;
    s_g = 8'd255;
    s_b = 8'd255;
    @(posedge clk);
    #1;
    check("rst_q", int'(pix.gs_q), 0);
    check("rst_peak", int'(pix.gs_peak), 0);
    check("rst_gs", int'(pix.gs), 0);

    drive(0, 0, 0, 1'b0);
    check("black", int'(pix.gs), 0);
    drive(255, 255, 255, 1'b0);
    check("white", int'(pix.gs), 255);
    drive(255, 0, 0, 1'b0);
    check("red", int'(pix.gs), EXP_R);
    drive(0, 255, 0, 1'b0);
    check("green", int'(pix.gs), 149);
    drive(0, 0, 255, 1'b0);
    check("blue", int'(pix.gs), EXP_B);

    drive(0, 0, 0, 1'b1);
    check("seq_q0", int'(pix.gs_q), 0);
    drive(10, 10, 10, 1'b0);
    check("seq_q1", int'(pix.gs_q), 10);
    check("seq_p1", int'(pix.gs_peak), 10);
    drive(200, 200, 200, 1'b0);
    check("seq_q2", int'(pix.gs_q), 200);
    check("seq_p2", int'(pix.gs_peak), 200);
    drive(50, 50, 50, 1'b0);
    check("seq_q3", int'(pix.gs_q), 50);
    check("seq_p3", int'(pix.gs_peak), 200);

    drive(50, 50, 50, 1'b1);
    check("mid_rst_gs", int'(pix.gs), 50);
    check("mid_rst_q", int'(pix.gs_q), 0);
    check("mid_rst_p", int'(pix.gs_peak), 0);
    drive(50, 50, 50, 1'b0);
    check("post_rst_q", int'(pix.gs_q), 50);
    check("post_rst_p", int'(pix.gs_peak), 50);

    check("sat_gs", int'(s_gs), 255);
    check("sat_peak", int'(s_pk), 255);

    for (int i = 0; i < 10000; i++) begin
      drive(int'($urandom_range(255)), int'($urandom_range(255)),
            int'($urandom_range(255)), ($urandom_range(63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
